// File: rtl/reg_file_if.sv
// Register-file access bus: two combinational read ports and one write port.
// w is a one-sided write strobe with no ready: the file always accepts a write on the clock edge.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              w;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    modport master (
        output w, rs1, rs2, rd, wdata,
        input  rdata1, rdata2
    );

    modport slave (
        input  w, rs1, rs2, rd, wdata,
        output rdata1, rdata2
    );
endinterface

// File: rtl/reg_file.sv
// 32 x 32 MIPS general-purpose register file: two combinational reads, one clocked write,
// register $0 hardwired to zero, asynchronous active-low clear.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Per-entry decode rather than regs[rd] so an unknown rd with w low can never touch storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (bus.w && (bus.rd == ADDR_W'(i))) begin
                    regs[i] <= bus.wdata;
                end
            end
        end
    end

    // No write bypass: a same-index read shows the old value until the write edge.
    assign bus.rdata1 = (bus.rs1 == '0) ? '0 : regs[bus.rs1];
    assign bus.rdata2 = (bus.rs2 == '0) ? '0 : regs[bus.rs2];
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: reset and corner sequences, a vector table, and random traffic
// compared against an array model of the architectural registers.
module tb_reg_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] model [32];

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
        bus.w     = 1'b1;
        bus.rd    = idx;
        bus.wdata = data;
        tick();
        bus.w = 1'b0;
        if (idx != 5'd0) model[idx] = data;
    endtask

    task automatic read_check(input string name, input logic [4:0] a1, input logic [4:0] a2);
        bus.rs1 = a1;
        bus.rs2 = a2;
        #1;
        check({name, "_rd1"}, bus.rdata1, model_read(a1));
        check({name, "_rd2"}, bus.rdata2, model_read(a2));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();
        rst_n     = 1'b0;
        bus.w     = 1'b0;
        bus.rd    = 5'd0;
        bus.wdata = 32'd0;
        bus.rs1   = 5'd7;
        bus.rs2   = 5'd31;

        vecs[0] = '{1'b1, 5'd0,  32'd12,         5'd0,  5'd0,  32'd0,          32'd0};
        vecs[1] = '{1'b1, 5'd1,  32'd14,         5'd0,  5'd1,  32'd0,          32'd14};
        vecs[2] = '{1'b0, 5'd1,  32'd99,         5'd0,  5'd1,  32'd0,          32'd14};
        vecs[3] = '{1'b0, 5'd1,  32'd99,         5'd1,  5'd1,  32'd14,         32'd14};
        vecs[4] = '{1'b0, 5'bxxxxx, 32'd99,      5'd1,  5'd1,  32'd14,         32'd14};
        vecs[5] = '{1'b1, 5'd5,  32'd7,          5'd5,  5'd1,  32'd7,          32'd14};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFF_FFFF,  5'd31, 5'd5,  32'hFFFF_FFFF,  32'd7};
        vecs[7] = '{1'b1, 5'd30, 32'd1,          5'd31, 5'd30, 32'hFFFF_FFFF,  32'd1};
        vecs[8] = '{1'b0, 5'd0,  32'd0,          5'd31, 5'd31, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[9] = '{1'b1, 5'd17, 32'hA5A5_A5A5,  5'd17, 5'd30, 32'hA5A5_A5A5,  32'd1};

        // Reset state, held reset
        #2;
        check("reset_rd1", bus.rdata1, 32'd0);
        check("reset_rd2", bus.rdata2, 32'd0);
        #5;
        rst_n = 1'b1;

        // Asynchronous clear mid-cycle after reg1=14
        do_write(5'd1, 32'd14);
        read_check("pre_async", 5'd1, 5'd0);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.rs1 = 5'd1;
        #1;
        check("async_clear", bus.rdata1, 32'd0);
        model_clear();

        // Reset wins over a coincident write
        bus.w     = 1'b1;
        bus.rd    = 5'd3;
        bus.wdata = 32'd5;
        tick();
        bus.w   = 1'b0;
        bus.rs1 = 5'd3;
        #1;
        check("reset_priority", bus.rdata1, 32'd0);
        #2;
        rst_n = 1'b1;

        // Vector table: apply write, one edge, then read both ports
        for (int i = 0; i < 10; i++) begin
            bus.w     = vecs[i].w;
            bus.rd    = vecs[i].rd;
            bus.wdata = vecs[i].wdata;
            tick();
            bus.w   = 1'b0;
            bus.rd  = 5'd0;
            bus.rs1 = vecs[i].rs1;
            bus.rs2 = vecs[i].rs2;
            #1;
            check($sformatf("vec%0d_rd1", i), bus.rdata1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), bus.rdata2, vecs[i].exp2);
            if (vecs[i].w === 1'b1 && vecs[i].rd != 5'd0) model[vecs[i].rd] = vecs[i].wdata;
        end

        // Idle edges leave registers untouched
        bus.rd    = 5'd1;
        bus.wdata = 32'd99;
        repeat (4) tick();
        read_check("idle_edges", 5'd0, 5'd1);

        // Read-during-write on reg5: old value before the edge, new value right after
        bus.w     = 1'b1;
        bus.rd    = 5'd5;
        bus.wdata = 32'hDEAD_BEEF;
        bus.rs1   = 5'd5;
        bus.rs2   = 5'd5;
        #1;
        check("rdw_before_rd1", bus.rdata1, 32'd7);
        check("rdw_before_rd2", bus.rdata2, 32'd7);
        tick();
        bus.w = 1'b0;
        model[5] = 32'hDEAD_BEEF;
        check("rdw_after_rd1", bus.rdata1, 32'hDEAD_BEEF);
        check("rdw_after_rd2", bus.rdata2, 32'hDEAD_BEEF);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic        rw;
            logic [4:0]  ridx;
            logic [31:0] rdat;
            logic [4:0]  a1;
            logic [4:0]  a2;
            rw   = 1'($urandom_range(0, 1));
            ridx = 5'($urandom_range(0, 31));
            rdat = $urandom;
            a1   = ($urandom_range(0, 3) == 0) ? ridx : 5'($urandom_range(0, 31));
            a2   = 5'($urandom_range(0, 31));
            bus.w     = rw;
            bus.rd    = ridx;
            bus.wdata = rdat;
            read_check($sformatf("rnd%0d_pre", n), a1, a2);
            tick();
            bus.w = 1'b0;
            if (rw && ridx != 5'd0) model[ridx] = rdat;
            read_check($sformatf("rnd%0d_post", n), a1, a2);
        end

        // Final asynchronous clear of the whole file
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            read_check($sformatf("final_clear%0d", i), 5'(i), 5'(31 - i));
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
